viterbi_out_pack_ctrl: RTL and testbench
========================================

# viterbi_out_pack_ctrl

Sequencing controller for the Viterbi decoder output path. It accepts decoded bits one at a time from the traceback stage under a valid/ready handshake and packs them into SIZE_OUT-bit words. It issues each word downstream with a valid/ready handshake and terminates frames, zero-padding a final partial word. It sits between the traceback unit and the byte-wide output port, and owns all output-side flow control.

## Interface

- SIZE_OUT, 8, output word width in bits (≥2).
- FRAME_LEN, 64, maximum decoded bits per frame (≥1); reaching it terminates the frame.
- i_clk  in  1  clock, all logic on rising edge.
- i_rst_n  in  1  reset; one clock, reset is asynchronous and active-low.
- i_frame_start  in  1  single-cycle pulse that opens a frame.
- i_bit_valid  in  1  decoded bit present.
- i_bit  in  1  decoded bit.
- i_bit_last  in  1  qualifies i_bit as final bit of frame (sampled with i_bit_valid).
- o_bit_ready  out  1  controller accepts a bit this cycle.
- o_data  out  SIZE_OUT  packed word.
- o_valid  out  1  o_data holds a word.
- o_last  out  1  word is the last of the frame (valid only with o_valid).
- i_out_ready  in  1  downstream takes o_data when o_valid && i_out_ready.
- o_err  out  1  single-cycle pulse: protocol error.

## Operation

- FSM states: IDLE, COLLECT, HOLD.
- IDLE: o_bit_ready=0. On i_frame_start, go to COLLECT, clear the bit counter (bcnt), the frame counter (fcnt) and the shift register.
- COLLECT: o_bit_ready=1. A bit is accepted when i_bit_valid=1. Accepted bits are packed MSB-first: the first bit of a word lands in o_data[SIZE_OUT-1].
- Word closes when SIZE_OUT bits have been accepted, when an accepted bit has i_bit_last=1, or when fcnt reaches FRAME_LEN. On close, go to HOLD and drive o_valid=1.
- A frame closes on i_bit_last or on reaching FRAME_LEN; o_last=1 for that word. The unfilled low bits of a partial word are 0.
- HOLD: o_bit_ready=0; o_data, o_valid and o_last stay stable until i_out_ready=1.
  - On handshake of a last word, go to IDLE.
  - On handshake of any other word, go to COLLECT with bcnt=0.
- bcnt width is $clog2(SIZE_OUT). fcnt width is $clog2(FRAME_LEN+1) and saturates; it never wraps.
- An i_frame_start in COLLECT or HOLD is ignored and pulses o_err the next cycle.
- i_bit_valid in IDLE or HOLD is not accepted and raises no error; the producer must hold the bit.

## Timing

- Reset values: o_bit_ready=0, o_data=0, o_valid=0, o_last=0, o_err=0; state IDLE; all counters 0.
- Reset asserted mid-frame aborts immediately; the partial word is discarded and not emitted after release.
- i_frame_start at edge N gives o_bit_ready=1 from cycle N+1.
- Closing bit accepted at edge N gives o_valid=1 from cycle N+1: 1-cycle latency.
- Handshake at edge M: o_valid=0 and o_bit_ready=1 in cycle M+1 (COLLECT), or 0 (IDLE).
- Sustained throughput: SIZE_OUT+1 cycles per word with i_out_ready held high. There is a single buffer; no overlap of collect and hold.
- A closing bit that has i_bit_last=1 and also completes SIZE_OUT bits produces exactly one word, with o_last=1.
- All outputs are registered; there is no combinational input-to-output path except none. o_bit_ready is derived from the state register only.

## Configuration

- VITERBI_OUT_LSB_FIRST_EN defined: bits are packed LSB-first. The first accepted bit goes to o_data[0]. Padding zeros occupy the unfilled high bits.
- Not defined (default): MSB-first packing as above. All timing and handshaking are identical in both builds.

## Test plan

- Reset then pulse start, feed 8 bits 1,0,1,1,0,0,1,0 with i_out_ready=1 → o_data=8'hB2, o_valid one cycle after 8th bit, o_last=0, then o_bit_ready=1.
- 3 bits 1,1,1 with i_bit_last on third → o_data=8'hE0, o_last=1, return to IDLE (o_bit_ready=0); with LSB_FIRST_EN → 8'h07.
- Full word ready but i_out_ready=0 for 5 cycles → o_data/o_valid stable, o_bit_ready=0, bit held by producer not lost; released on ready.
- FRAME_LEN=12, 12 bits of all-ones, no i_bit_last → words 8'hFF (o_last=0) then 8'hF0 (o_last=1).
- i_frame_start pulsed during COLLECT → o_err=1 for one cycle, counters unchanged, packed data correct.
- Assert i_rst_n=0 after 4 bits, release, restart frame with 8 zeros → single word 8'h00, no remnant of aborted frame.

Source files
------------

// File: rtl/viterbi_out_pack_ctrl.sv
// Packs decoded bits from the traceback stage into SIZE_OUT-bit words and hands them downstream.
// Define VITERBI_OUT_LSB_FIRST_EN to pack LSB-first; the default build packs MSB-first.
module viterbi_out_pack_ctrl #(
  parameter int SIZE_OUT  = 8,
  parameter int FRAME_LEN = 64
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_frame_start,
  input  logic                i_bit_valid,
  input  logic                i_bit,
  input  logic                i_bit_last,
  output logic                o_bit_ready,
  output logic [SIZE_OUT-1:0] o_data,
  output logic                o_valid,
  output logic                o_last,
  input  logic                i_out_ready,
  output logic                o_err
);

  localparam int BW = (SIZE_OUT > 1) ? $clog2(SIZE_OUT) : 1;
  localparam int FW = $clog2(FRAME_LEN + 1);

  typedef enum logic [1:0] {IDLE, COLLECT, HOLD} state_t;

  state_t              state, next_state;
  logic [BW-1:0]       bcnt;
  logic [FW-1:0]       fcnt, fcnt_inc;
  logic [SIZE_OUT-1:0] shreg, shreg_next;
  logic [BW-1:0]       bit_pos;
  logic                accept, word_full, frame_end, close;

  assign o_bit_ready = (state == COLLECT);
  assign o_valid     = (state == HOLD);

  assign accept    = (state == COLLECT) && i_bit_valid;
  assign word_full = (bcnt == BW'(SIZE_OUT - 1));
  assign fcnt_inc  = (fcnt == FW'(FRAME_LEN)) ? fcnt : fcnt + 1'b1;
  assign frame_end = i_bit_last || (fcnt_inc == FW'(FRAME_LEN));
  assign close     = accept && (word_full || frame_end);

`ifdef VITERBI_OUT_LSB_FIRST_EN
  assign bit_pos = bcnt;
`else
  assign bit_pos = BW'(SIZE_OUT - 1) - bcnt;
`endif

  // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    next_state = state;
    shreg_next = shreg;
    if (accept) shreg_next[bit_pos] = i_bit;
    case (state)
      IDLE:    if (i_frame_start) next_state = COLLECT;
      COLLECT: if (close) next_state = HOLD;
      HOLD:    if (i_out_ready) next_state = o_last ? IDLE : COLLECT;
      default: next_state = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state  <= IDLE;
      bcnt   <= '0;
      fcnt   <= '0;
      shreg  <= '0;
      o_data <= '0;
      o_last <= 1'b0;
      o_err  <= 1'b0;
    end else begin
      state <= next_state;
      o_err <= i_frame_start && (state != IDLE);
      case (state)
        IDLE: begin
          if (i_frame_start) begin
            bcnt  <= '0;
            fcnt  <= '0;
            shreg <= '0;
          end
        end
        COLLECT: begin
          if (accept) begin
            bcnt  <= bcnt + 1'b1;
            fcnt  <= fcnt_inc;
            shreg <= shreg_next;
          end
          // The closing bit goes straight into the output word, so it leaves one cycle later.
          if (close) begin
            o_data <= shreg_next;
            o_last <= frame_end;
          end
        end
        HOLD: begin
          if (i_out_ready) begin
            bcnt   <= '0;
            shreg  <= '0;
            o_last <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_viterbi_out_pack_ctrl.sv
// Self-checking bench for viterbi_out_pack_ctrl: directed table, timing sequences, random frames vs a model.
module tb_viterbi_out_pack_ctrl;

  localparam int SIZE_OUT  = 8;
  localparam int FRAME_LEN = 12;

  logic                i_clk = 1'b0;
  logic                i_rst_n;
  logic                i_frame_start, i_bit_valid, i_bit, i_bit_last, i_out_ready;
  logic                o_bit_ready, o_valid, o_last, o_err;
  logic [SIZE_OUT-1:0] o_data;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [SIZE_OUT-1:0] data;
    logic                last;
  } word_t;

  typedef struct {
    int                  nbits;
    logic [15:0]         bits;   // first bit sent is bits[nbits-1]
    bit                  use_last;
    int                  nwords;
    logic [SIZE_OUT-1:0] w0;     // expected words written MSB-first
    logic                l0;
    logic [SIZE_OUT-1:0] w1;
    logic                l1;
  } vec_t;

  word_t got_q[$];
  word_t exp_q[$];

  viterbi_out_pack_ctrl #(.SIZE_OUT(SIZE_OUT), .FRAME_LEN(FRAME_LEN)) dut (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .i_frame_start (i_frame_start),
    .i_bit_valid   (i_bit_valid),
    .i_bit         (i_bit),
    .i_bit_last    (i_bit_last),
    .o_bit_ready   (o_bit_ready),
    .o_data        (o_data),
    .o_valid       (o_valid),
    .o_last        (o_last),
    .i_out_ready   (i_out_ready),
    .o_err         (o_err)
  );

  always #5 i_clk = ~i_clk;

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Converts an MSB-first word into the ordering of the current build.
  function automatic logic [SIZE_OUT-1:0] order(input logic [SIZE_OUT-1:0] msb_word);
`ifdef VITERBI_OUT_LSB_FIRST_EN
    logic [SIZE_OUT-1:0] r;
    for (int i = 0; i < SIZE_OUT; i++) r[i] = msb_word[SIZE_OUT-1-i];
    return r;
`else
    return msb_word;
`endif
  endfunction

  // Reference: walk the bit list, cut words at SIZE_OUT bits, at the last flag or at FRAME_LEN.
  task automatic model(input int nbits, input logic [15:0] bits, input bit use_last);
    int                  pos = 0;
    logic [SIZE_OUT-1:0] w   = '0;
    exp_q = {};
    for (int i = 0; i < nbits && i < FRAME_LEN; i++) begin
      bit fin;
      fin = (use_last && i == nbits - 1) || (i + 1 == FRAME_LEN);
`ifdef VITERBI_OUT_LSB_FIRST_EN
      w[pos] = bits[nbits-1-i];
`else
      w[SIZE_OUT-1-pos] = bits[nbits-1-i];
`endif
      pos++;
      if (pos == SIZE_OUT || fin) begin
        exp_q.push_back('{data: w, last: fin});
        w   = '0;
        pos = 0;
      end
    end
  endtask

  // Sends one frame with random valid/ready gaps; the producer holds a bit until it is accepted.
  task automatic run_frame(input string tag, input int nbits, input logic [15:0] bits,
                           input bit use_last, input int vpct, input int rpct);
    int                  idx = 0;
    int                  cyc = 0;
    bit                  acc, hs, stall, err_seen, overlap;
    logic [SIZE_OUT-1:0] held_data;
    logic                held_last;
    got_q         = {};
    err_seen      = 0;
    overlap       = 0;
    i_bit_valid   = 1'b0;
    i_frame_start = 1'b1;
    step();
    i_frame_start = 1'b0;
    check({tag, " ready_after_start"}, 32'(o_bit_ready), 32'd1);
    while (!(got_q.size() > 0 && got_q[$].last) && cyc < 400) begin
      if (!i_bit_valid) begin
        if (idx < nbits && $urandom_range(99) < 32'(vpct)) begin
          i_bit_valid = 1'b1;
          i_bit       = bits[nbits-1-idx];
          i_bit_last  = use_last && (idx == nbits - 1);
        end else begin
          i_bit      = 1'($urandom);
          i_bit_last = 1'($urandom);
        end
      end
      i_out_ready = ($urandom_range(99) < 32'(rpct));
      acc       = o_bit_ready && i_bit_valid;
      hs        = o_valid && i_out_ready;
      stall     = o_valid && !i_out_ready;
      held_data = o_data;
      held_last = o_last;
      if (hs) got_q.push_back('{data: o_data, last: o_last});
      if (o_valid && o_bit_ready) overlap = 1;
      step();
      cyc++;
      if (o_err) err_seen = 1;
      if (acc) begin
        idx++;
        i_bit_valid = 1'b0;
      end
      if (stall) begin
        check({tag, " hold_valid"}, 32'(o_valid), 32'd1);
        check({tag, " hold_data"}, 32'({held_last, held_data}), 32'({o_last, o_data}));
      end
    end
    i_bit_valid = 1'b0;
    i_out_ready = 1'b0;
    check({tag, " timeout"}, 32'(cyc < 400), 32'd1);
    check({tag, " bits_consumed"}, 32'(idx), 32'(nbits));
    check({tag, " back_to_idle"}, 32'({o_bit_ready, o_valid}), 32'd0);
    check({tag, " no_err"}, 32'(err_seen), 32'd0);
    check({tag, " no_overlap"}, 32'(overlap), 32'd0);
  endtask

  task automatic compare_words(input string tag);
    check({tag, " word_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      check($sformatf("%s word%0d_data", tag, i), 32'(got_q[i].data), 32'(exp_q[i].data));
      check($sformatf("%s word%0d_last", tag, i), 32'(got_q[i].last), 32'(exp_q[i].last));
    end
  endtask

  task automatic send_bit(input logic b, input logic last);
    i_bit_valid = 1'b1;
    i_bit       = b;
    i_bit_last  = last;
    step();
  endtask

  initial begin
    vec_t                vecs[7];
    logic [SIZE_OUT-1:0] pat;
    vecs[0] = '{9,  16'h0165, 1'b1, 2, 8'hB2, 1'b0, 8'h80, 1'b1};
    vecs[1] = '{3,  16'h0007, 1'b1, 1, 8'hE0, 1'b1, 8'h00, 1'b0};
    vecs[2] = '{12, 16'h0FFF, 1'b0, 2, 8'hFF, 1'b0, 8'hF0, 1'b1};
    vecs[3] = '{8,  16'h0000, 1'b1, 1, 8'h00, 1'b1, 8'h00, 1'b0};
    vecs[4] = '{1,  16'h0001, 1'b1, 1, 8'h80, 1'b1, 8'h00, 1'b0};
    vecs[5] = '{12, 16'h0A59, 1'b1, 2, 8'hA5, 1'b0, 8'h90, 1'b1};
    vecs[6] = '{12, 16'h0FFF, 1'b1, 2, 8'hFF, 1'b0, 8'hF0, 1'b1};

    i_rst_n = 1'b0;
    i_frame_start = 1'b0;
    i_bit_valid = 1'b0;
    i_bit = 1'b0;
    i_bit_last = 1'b0;
    i_out_ready = 1'b0;
    step();
    step();
    check("reset_outputs", 32'({o_bit_ready, o_valid, o_last, o_err, o_data}), 32'd0);
    i_rst_n = 1'b1;
    step();
    check("idle_after_reset", 32'({o_bit_ready, o_valid, o_err}), 32'd0);

    // A bit offered in IDLE is neither accepted nor flagged.
    i_bit_valid = 1'b1;
    i_bit = 1'b1;
    step();
    step();
    check("idle_ignores_bits", 32'({o_bit_ready, o_valid, o_err}), 32'd0);
    i_bit_valid = 1'b0;

    // Word B2, back-pressure for 5 cycles, then a start pulse mid-collect.
    pat = 8'hB2;
    i_frame_start = 1'b1;
    step();
    i_frame_start = 1'b0;
    check("seq_ready_n_plus_1", 32'(o_bit_ready), 32'd1);
    for (int i = 0; i < SIZE_OUT; i++) begin
      check("seq_no_valid_while_collecting", 32'(o_valid), 32'd0);
      send_bit(pat[SIZE_OUT-1-i], 1'b0);
    end
    check("seq_valid_latency", 32'(o_valid), 32'd1);
    check("seq_word_b2", 32'(o_data), 32'(order(8'hB2)));
    check("seq_b2_not_last", 32'(o_last), 32'd0);
    check("seq_ready_low_in_hold", 32'(o_bit_ready), 32'd0);
    i_bit_valid = 1'b1;
    i_bit = 1'b1;
    i_bit_last = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check("seq_stall_stable", 32'({o_valid, o_bit_ready, o_last, o_data}),
            32'({2'b10, 1'b0, order(8'hB2)}));
    end
    i_out_ready = 1'b1;
    step();
    check("seq_after_handshake", 32'({o_valid, o_bit_ready}), 32'b01);
    i_frame_start = 1'b1;
    send_bit(1'b1, 1'b0);
    i_frame_start = 1'b0;
    check("seq_err_pulse", 32'(o_err), 32'd1);
    send_bit(1'b1, 1'b0);
    check("seq_err_single_cycle", 32'(o_err), 32'd0);
    send_bit(1'b1, 1'b1);
    i_bit_valid = 1'b0;
    i_bit_last = 1'b0;
    check("seq_word_e0", 32'({o_valid, o_last, o_data}), 32'({2'b11, order(8'hE0)}));
    step();
    check("seq_idle_after_last", 32'({o_valid, o_bit_ready}), 32'd0);
    i_out_ready = 1'b0;

    // Reset mid-frame discards the partial word.
    i_frame_start = 1'b1;
    step();
    i_frame_start = 1'b0;
    for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b0);
    i_bit_valid = 1'b0;
    i_rst_n = 1'b0;
    #2;
    check("async_reset", 32'({o_bit_ready, o_valid, o_last, o_data}), 32'd0);
    step();
    i_rst_n = 1'b1;
    step();
    check("no_emit_after_reset", 32'({o_valid, o_bit_ready}), 32'd0);
    run_frame("restart", 8, 16'h0000, 1'b1, 100, 100);
    model(8, 16'h0000, 1'b1);
    compare_words("restart");
    check("restart_single_word", 32'({got_q.size() == 1, got_q.size() > 0 ? got_q[0].data : 8'hxx}),
          32'({1'b1, 8'h00}));

    for (int v = 0; v < 7; v++) begin
      string tag;
      tag = $sformatf("vec%0d", v);
      run_frame(tag, vecs[v].nbits, vecs[v].bits, vecs[v].use_last, 100, 100);
      exp_q = {};
      exp_q.push_back('{data: order(vecs[v].w0), last: vecs[v].l0});
      if (vecs[v].nwords > 1) exp_q.push_back('{data: order(vecs[v].w1), last: vecs[v].l1});
      compare_words(tag);
    end

    for (int f = 0; f < 40; f++) begin
      int          n;
      bit          ul;
      logic [15:0] rb;
      string       tag;
      tag = $sformatf("rnd%0d", f);
      n   = $urandom_range(FRAME_LEN, 1);
      ul  = (n < FRAME_LEN) ? 1'b1 : 1'($urandom);
      rb  = 16'($urandom);
      run_frame(tag, n, rb, ul, $urandom_range(100, 30), $urandom_range(100, 30));
      model(n, rb, ul);
      compare_words(tag);
      repeat ($urandom_range(3)) step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
